// File: rtl/i_cache_line.sv
// i_cache_line: direct-mapped instruction cache with multi-word lines.
//
// Serves fetch hits combinationally. A miss fills the whole line with
// LINE_WORDS sequential single-beat AXI4-Lite reads, then commits the
// line. Supports a full invalidate (flush) and reports bus errors.
//
// Optional feature macro: ICACHE_STATS_EN (adds hit_count / miss_count).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   addr                  fetch byte address (bits [1:0] ignored)
//   data, data_valid      instruction word at addr, valid this cycle
//   flush                 invalidate all lines (pulse or level)
//   busy                  fill or flush in progress
//   bus_error             1-cycle pulse when a fill beat returns rresp!=0
//   arvalid/arready/araddr/arprot   AXI read address channel
//   rvalid/rready/rdata/rresp       AXI read data channel
//   hit_count, miss_count (ICACHE_STATS_EN only) wrapping 32-bit counters
module i_cache_line #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       data,
  output logic              data_valid,
  input  logic              flush,
  output logic              busy,
  output logic              bus_error,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int BEAT_W     = (OFF_W < 1) ? 1 : OFF_W;
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int TAG_W      = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int LINE_BYTES = LINE_WORDS * 4;

  typedef enum logic [2:0] {
    S_LOOKUP,
    S_ADDR,
    S_DATA,
    S_COMMIT,
    S_FLUSH
  } state_t;

  state_t state, state_n;

  // Storage: only the valid bits are reset.
  logic [31:0]      data_arr [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_arr  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [31:0]      line_buf [LINE_WORDS];

  // Fill bookkeeping
  logic [ADDR_W-1:0] base, base_n;
  logic [BEAT_W-1:0] beat, beat_n;
  logic              pend, pend_n;
  logic              arvalid_n, rready_n, bus_error_n;
  logic [ADDR_W-1:0] araddr_n;
  logic              commit, flush_all, buf_we;

  // Lookup fields from the live fetch address
  logic [BEAT_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;

  // Fields of the line being filled
  logic [IDX_W-1:0]  bidx;
  logic [TAG_W-1:0]  btag;

  // Offset is masked so LINE_WORDS=1 yields a constant zero offset.
  assign off  = BEAT_W'((addr >> 2) & ADDR_W'(LINE_WORDS - 1));
  assign idx  = IDX_W'(addr >> (2 + OFF_W));
  assign tag  = TAG_W'(addr >> (2 + OFF_W + IDX_W));
  assign bidx = IDX_W'(base >> (2 + OFF_W));
  assign btag = TAG_W'(base >> (2 + OFF_W + IDX_W));

  assign hit        = valid[idx] && (tag_arr[idx] == tag);
  assign data       = data_arr[idx][off];
  assign data_valid = (state == S_LOOKUP) && hit && !flush;
  assign busy       = (state != S_LOOKUP);
  assign arprot     = 3'b101;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOOKUP;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      araddr    <= '0;
      base      <= '0;
      beat      <= '0;
      pend      <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_n;
      arvalid   <= arvalid_n;
      rready    <= rready_n;
      araddr    <= araddr_n;
      base      <= base_n;
      beat      <= beat_n;
      pend      <= pend_n;
      bus_error <= bus_error_n;
    end
  end

  always_comb begin
    state_n     = state;
    arvalid_n   = arvalid;
    rready_n    = rready;
    araddr_n    = araddr;
    base_n      = base;
    beat_n      = beat;
    pend_n      = pend;
    bus_error_n = 1'b0;
    commit      = 1'b0;
    flush_all   = 1'b0;
    buf_we      = 1'b0;
    case (state)
      S_LOOKUP: begin
        if (flush) begin
          state_n = S_FLUSH;
        end else if (!hit) begin
          base_n    = addr & ~ADDR_W'(LINE_BYTES - 1);
          beat_n    = '0;
          arvalid_n = 1'b1;
          araddr_n  = base_n;
          state_n   = S_ADDR;
        end
      end
      S_ADDR: begin
        pend_n = pend || flush;
        if (arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        pend_n = pend || flush;
        if (rvalid && rready) begin
          buf_we   = 1'b1;
          rready_n = 1'b0;
          if (rresp != 2'b00) begin
            bus_error_n = 1'b1;
            pend_n      = 1'b0;
            state_n     = (pend || flush) ? S_FLUSH : S_LOOKUP;
          end else if (beat == BEAT_W'(LINE_WORDS - 1)) begin
            state_n = S_COMMIT;
          end else begin
            beat_n    = beat + 1'b1;
            araddr_n  = base + (ADDR_W'(beat_n) << 2);
            arvalid_n = 1'b1;
            state_n   = S_ADDR;
          end
        end
      end
      S_COMMIT: begin
        // Commit even with a flush pending; the FLUSH that follows
        // clears the line again.
        commit  = 1'b1;
        pend_n  = 1'b0;
        state_n = (pend || flush) ? S_FLUSH : S_LOOKUP;
      end
      S_FLUSH: begin
        flush_all = 1'b1;
        pend_n    = 1'b0;
        state_n   = S_LOOKUP;
      end
      default: state_n = S_LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (flush_all) begin
      valid <= '0;
    end else if (commit) begin
      valid[bidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[beat] <= rdata;
    end
    if (commit) begin
      tag_arr[bidx] <= btag;
      for (int unsigned w = 0; w < LINE_WORDS; w++) begin
        data_arr[bidx][BEAT_W'(w)] <= line_buf[w];
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [ADDR_W-1:0] last_addr;
  logic              last_ok;
  logic              miss_start;

  assign miss_start = (state == S_LOOKUP) && (state_n == S_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      last_addr  <= '0;
      last_ok    <= 1'b0;
    end else begin
      if (miss_start) begin
        miss_count <= miss_count + 1'b1;
      end
      // A fetch held on the same address is counted once.
      if (data_valid && !(last_ok && (addr == last_addr))) begin
        hit_count <= hit_count + 1'b1;
        last_addr <= addr;
        last_ok   <= 1'b1;
      end
    end
  end
`endif

endmodule
